// File: rtl/squeeze_serial_out.sv
// SHAKE256 output serializer: rate blocks in, 2-bit digest chunks out.
// Define SQUEEZE_MSB_FIRST_EN to emit each byte's chunks MSB-first.
module squeeze_serial_out #(
  parameter int RANGE = 1088
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             squeeze_start,
  input  logic [15:0]      out_bytes,
  input  logic [RANGE-1:0] block_in,
  input  logic             block_valid,
  output logic             block_ready,
  output logic             next_block,
  output logic [1:0]       serial_out,
  output logic             serial_valid,
  input  logic             serial_ready,
  output logic             serial_end_signal,
  output logic             squeeze_done,
  output logic [2:0]       debug_state,
  output logic [10:0]      debug_bytecount
);

  localparam int BYTE_RANGE = RANGE / 8;
  localparam int BW = $clog2(BYTE_RANGE + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_SHIFT = 3'd2,
    S_REQ   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [RANGE-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    byte_idx_q, byte_idx_d;
  logic [1:0]       chunk_idx_q, chunk_idx_d;
  logic [15:0]      remaining_q, remaining_d;

  logic hs;
  logic byte_end;

  // The shifter always drains bits [1:0] first; MSB-first order is
  // obtained by reversing chunk order inside each byte at load time.
  function automatic logic [RANGE-1:0] order_block(
    input logic [RANGE-1:0] b
  );
    logic [RANGE-1:0] r;
    r = b;
`ifdef SQUEEZE_MSB_FIRST_EN
    for (int k = 0; k < BYTE_RANGE; k++) begin
      r[8*k +: 8] = {b[8*k +: 2], b[8*k+2 +: 2],
                     b[8*k+4 +: 2], b[8*k+6 +: 2]};
    end
`endif
    return r;
  endfunction

  assign hs       = (state_q == S_SHIFT) && serial_ready;
  assign byte_end = hs && (chunk_idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      shreg_q     <= '0;
      byte_idx_q  <= '0;
      chunk_idx_q <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      byte_idx_q  <= byte_idx_d;
      chunk_idx_q <= chunk_idx_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (squeeze_start) begin
          state_d = (out_bytes == 16'd0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (block_valid) state_d = S_SHIFT;
      end
      S_SHIFT: begin
        // Digest completion wins over block exhaustion.
        if (byte_end) begin
          if (remaining_q <= 16'd1) begin
            state_d = S_DONE;
          end else if (byte_idx_q == BW'(BYTE_RANGE - 1)) begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ:   state_d = S_WAIT;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    shreg_d     = shreg_q;
    byte_idx_d  = byte_idx_q;
    chunk_idx_d = chunk_idx_q;
    remaining_d = remaining_q;
    unique case (state_q)
      S_IDLE: begin
        if (squeeze_start) remaining_d = out_bytes;
      end
      S_WAIT: begin
        if (block_valid) begin
          shreg_d     = order_block(block_in);
          byte_idx_d  = '0;
          chunk_idx_d = '0;
        end
      end
      S_SHIFT: begin
        if (hs) begin
          shreg_d     = shreg_q >> 2;
          chunk_idx_d = chunk_idx_q + 2'd1;
        end
        if (byte_end) begin
          byte_idx_d  = byte_idx_q + BW'(1);
          remaining_d = (remaining_q != 16'd0)
                      ? remaining_q - 16'd1 : 16'd0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    block_ready       = (state_q == S_WAIT);
    next_block        = (state_q == S_REQ);
    serial_valid      = (state_q == S_SHIFT);
    serial_out        = serial_valid ? shreg_q[1:0] : 2'b00;
    serial_end_signal = (state_q == S_DONE);
    squeeze_done      = (state_q == S_DONE);
    debug_state       = state_q;
    debug_bytecount   = 11'(byte_idx_q);
  end

endmodule

// File: tb/tb_squeeze_serial_out.sv
// Randomized bench for squeeze_serial_out against a byte-queue model.
// Expected chunks come straight from digest bytes and the chunk order rule.
module tb_squeeze_serial_out;

  localparam int RANGE = 1088;
  localparam int BR    = 136;
  localparam int MEMSZ = 3 * BR;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             squeeze_start = 1'b0;
  logic [15:0]      out_bytes = '0;
  logic [RANGE-1:0] block_in;
  logic             block_valid = 1'b0;
  logic             block_ready;
  logic             next_block;
  logic [1:0]       serial_out;
  logic             serial_valid;
  logic             serial_ready = 1'b0;
  logic             serial_end_signal;
  logic             squeeze_done;
  logic [2:0]       debug_state;
  logic [10:0]      debug_bytecount;

  squeeze_serial_out #(.RANGE(RANGE)) dut (
    .clk(clk),
    .reset(reset),
    .squeeze_start(squeeze_start),
    .out_bytes(out_bytes),
    .block_in(block_in),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .next_block(next_block),
    .serial_out(serial_out),
    .serial_valid(serial_valid),
    .serial_ready(serial_ready),
    .serial_end_signal(serial_end_signal),
    .squeeze_done(squeeze_done),
    .debug_state(debug_state),
    .debug_bytecount(debug_bytecount)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0] mem [MEMSZ];
  logic [1:0] exp_q [$];
  int  rdy_pct = 100;
  bit  mon_on = 0;
  int  cyc = 0;
  int  hs = 0;
  int  nb_cnt = 0;
  int  first_v = -1;
  int  last_hs = 0;
  bit  end_due = 0;
  bit  finished = 0;
  bit  saw_br = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  // Chunk j (0..3) of a digest byte, in emission order.
  function automatic logic [1:0] chunk_of(input logic [7:0] b,
                                          input int j);
`ifdef SQUEEZE_MSB_FIRST_EN
    return b[(6 - 2*j) +: 2];
`else
    return b[2*j +: 2];
`endif
  endfunction

  function automatic logic [7:0] seq4(input logic [7:0] b);
    return {chunk_of(b, 0), chunk_of(b, 1),
            chunk_of(b, 2), chunk_of(b, 3)};
  endfunction

  // Block k of the digest stream is bytes k*136.. of mem.
  always_comb begin
    block_in = '0;
    for (int k = 0; k < BR; k++) begin
      if (nb_cnt * BR + k < MEMSZ) begin
        block_in[8*k +: 8] = mem[nb_cnt * BR + k];
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      serial_ready = ($urandom_range(99) < rdy_pct);
      block_valid  = ($urandom_range(3) != 0);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if (block_ready) saw_br = 1;
      if (!serial_valid) chk("out_zero_when_invalid", 32'(serial_out), 0);
      chk("done_eq_end", 32'(squeeze_done), 32'(serial_end_signal));
      chk("bytecount_max", 32'(debug_bytecount > 11'd136), 0);
      if (end_due) begin
        chk("end_pulse", 32'(serial_end_signal), 1);
        end_due  = 0;
        finished = 1;
      end else begin
        chk("no_stray_end", 32'(serial_end_signal), 0);
      end
      if (next_block) begin
        nb_cnt++;
        chk("next_block_pos", 32'(hs), 32'(4 * BR * nb_cnt));
      end
      if (serial_valid) begin
        chk("chunk_available", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("chunk", 32'(serial_out), 32'(exp_q[0]));
          if (first_v < 0) first_v = cyc;
          if (serial_ready) begin
            void'(exp_q.pop_front());
            hs++;
            last_hs = cyc;
            if (exp_q.size() == 0) end_due = 1;
          end
        end
      end
    end
  end

  task automatic clear_mon();
    exp_q.delete();
    hs = 0;
    nb_cnt = 0;
    first_v = -1;
    last_hs = 0;
    end_due = 0;
    finished = 0;
    saw_br = 0;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < MEMSZ; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_digest(input int n);
    clear_mon();
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) exp_q.push_back(chunk_of(mem[i], j));
    end
    mon_on = 1;
    @(posedge clk);
    #1;
    squeeze_start = 1'b1;
    out_bytes = 16'(n);
    @(posedge clk);
    #1;
    squeeze_start = 1'b0;
    if (n == 0) end_due = 1;
    for (int c = 0; c < 20000 && !finished; c++) @(posedge clk);
    chk("finished", 32'(finished), 1);
    chk("handshakes", 32'(hs), 32'(4 * n));
    chk("next_block_count", 32'(nb_cnt),
        32'((n == 0) ? 0 : (n - 1) / BR));
    if (n == 0) chk("zero_no_block_ready", 32'(saw_br), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEMSZ; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_outputs",
        32'({block_ready, next_block, serial_out, serial_valid,
             serial_end_signal, squeeze_done, debug_state,
             debug_bytecount}), 0);
    chk("reset_state", 32'(debug_state), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("no_ready_before_start", 32'(block_ready), 0);
    end

`ifdef SQUEEZE_MSB_FIRST_EN
    chk("pin_61", 32'(seq4(8'h61)), 32'(8'b01_10_00_01));
    chk("pin_a5", 32'(seq4(8'hA5)), 32'(8'b10_10_01_01));
`else
    chk("pin_61", 32'(seq4(8'h61)), 32'(8'b01_00_10_01));
    chk("pin_62", 32'(seq4(8'h62)), 32'(8'b10_00_10_01));
    chk("pin_63", 32'(seq4(8'h63)), 32'(8'b11_00_10_01));
    chk("pin_a5", 32'(seq4(8'hA5)), 32'(8'b01_01_10_10));
`endif

    rdy_pct = 100;
    fill_mem();
    mem[0] = 8'h61;
    mem[1] = 8'h62;
    mem[2] = 8'h63;
    run_digest(3);
    chk("abc_consecutive", 32'(last_hs - first_v), 11);

    fill_mem();
    mem[BR] = 8'hA5;
    run_digest(137);

    fill_mem();
    run_digest(BR);

    rdy_pct = 50;
    for (int t = 0; t < 4; t++) begin
      fill_mem();
      run_digest(int'($urandom_range(272, 1)));
    end
    fill_mem();
    run_digest(272);

    rdy_pct = 100;
    run_digest(0);

    mon_on = 0;
    clear_mon();
    fill_mem();
    @(posedge clk);
    #1;
    squeeze_start = 1'b1;
    out_bytes = 16'd50;
    @(posedge clk);
    #1;
    squeeze_start = 1'b0;
    for (int c = 0; c < 2000 && debug_bytecount != 11'd10; c++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_byte10", 32'(debug_bytecount), 10);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_outputs",
        32'({block_ready, next_block, serial_out, serial_valid,
             serial_end_signal, squeeze_done, debug_state,
             debug_bytecount}), 0);
    reset = 1'b0;
    fill_mem();
    run_digest(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/squeeze_serial_out.md
# squeeze_serial_out

- Output-side serializer of the SHAKE256 core: the inverse of the input `pad` collector.
- Takes rate-width (RANGE-bit) squeezed blocks from the permutation and emits an `out_bytes`-long digest as 2-bit chunks, bytes in ascending order.
- Requests one further permutation with a `next_block` pulse whenever a block is exhausted and more output is needed.
- Pulses `serial_end_signal` once after the final chunk.

## Interface
- RANGE, 1088, rate block width in bits; must be a multiple of 8 (BYTE_RANGE = RANGE/8 = 136).
- clk  in  1  clock; all state changes on posedge.
- reset  in  1  synchronous, active-high.
- squeeze_start  in  1  1-cycle start pulse; honoured only in IDLE.
- out_bytes  in  16  digest length in bytes; latched on accepted `squeeze_start`.
- block_in  in  RANGE  squeezed rate block; byte k = `block_in[8k+7:8k]`.
- block_valid  in  1  `block_in` valid.
- block_ready  out  1  high only in WAIT_BLOCK.
- next_block  out  1  1-cycle request for the next permutation.
- serial_out  out  2  current chunk; forced to 2'b00 when `serial_valid` is low.
- serial_valid  out  1  high only in SHIFT.
- serial_ready  in  1  consumer accepts the chunk on the clock edge where `serial_valid && serial_ready`.
- serial_end_signal  out  1  1-cycle pulse after the last chunk.
- squeeze_done  out  1  1-cycle pulse, coincident with `serial_end_signal`.
- debug_state  out  3  FSM encoding.
- debug_bytecount  out  11  byte index within the current block.

## Operation
- **FSM encoding:** IDLE=0, WAIT_BLOCK=1, SHIFT=2, REQ=3, DONE=4.
- **IDLE**
  - On `squeeze_start`, latch `remaining <= out_bytes`.
  - If `out_bytes==0`, go to DONE; otherwise go to WAIT_BLOCK.
- **WAIT_BLOCK**
  - `block_ready=1`.
  - On `block_valid`: load the RANGE-bit shift register from `block_in`, clear `byte_idx` and `chunk_idx`, go to SHIFT.
- **SHIFT**
  - `serial_valid=1`; `serial_out` = shift register bits [1:0].
  - On each handshake: shift right by 2 and increment `chunk_idx` (2 bits, wraps).
  - On the handshake with `chunk_idx==3`: increment `byte_idx` and decrement `remaining`.
  - Exit on that byte-completing handshake:
    - `remaining` reaches 0: go to DONE. This has priority over block exhaustion.
    - Otherwise `byte_idx` reaches BYTE_RANGE: go to REQ.
- **REQ:** `next_block=1` for exactly one cycle, then WAIT_BLOCK.
- **DONE:** `serial_end_signal=1` and `squeeze_done=1` for one cycle, then IDLE.
- **Idle-time inputs:**
  - `squeeze_start` outside IDLE is ignored.
  - `block_valid` outside WAIT_BLOCK is ignored.
- **Stalls:** while `serial_valid && !serial_ready`, `serial_out` and all internal state hold.
- **Reset**, including mid-operation:
  - FSM goes to IDLE.
  - Shift register, counters and `remaining` are cleared.
  - Every output is 0, including `debug_*`.
- **debug_bytecount:** equals `byte_idx` zero-extended to 11 bits; it is never above 136.
- **Counter arithmetic:**
  - `remaining` is a 16-bit counter; it is never decremented below 0.
  - Maximum digest length is 65535 bytes.

## Timing
- **Start:** `squeeze_start` sampled at edge N → `block_ready` high from cycle N+1.
- **First chunk:** block accepted at edge M → `serial_valid` high in cycle M+1 carrying chunk 0.
- **Throughput:** with `serial_ready` held high, one chunk per cycle, 4 cycles per byte, no bubbles within a block.
- **Block boundary:** after the last chunk of a block, REQ occupies one cycle, then WAIT_BLOCK. The minimum gap with no valid chunk is 2 cycles plus the permutation latency.
- **End of stream:** last chunk accepted at edge L → `serial_end_signal` high in cycle L+1. FSM is in IDLE at L+2 and can accept a new `squeeze_start` in that cycle.
- **Zero-length request:** `out_bytes==0` → DONE pulse in the cycle after start, with no `block_ready` and no `next_block`.

## Configuration
- `SQUEEZE_MSB_FIRST_EN` undefined (default): within each byte, chunks are emitted LSB-first, bits[1:0], [3:2], [5:4], [7:6]. This is the same order `pad` consumes.
- `SQUEEZE_MSB_FIRST_EN` defined: within each byte, chunks are emitted bits[7:6], [5:4], [3:2], [1:0].
- Byte order, handshakes and timing are identical in both builds.

## Test plan
- Reset held 3 cycles, then released → every output 0 and `debug_state=0`; `block_ready` stays 0 until `squeeze_start`.
- `out_bytes=3`, block bytes 0x61,0x62,0x63, `serial_ready=1`:
  - Chunks are 01,00,10,01, 10,00,10,01, 11,00,10,01 on 12 consecutive cycles.
  - `serial_end_signal` pulses once, the next cycle.
  - `next_block` never asserts.
- `out_bytes=137`:
  - Exactly one `next_block` pulse, after chunk 544.
  - Second block's byte 0 (0xA5) is sent as 01,01,10,10.
  - 548 chunks in total, then end pulse.
- Backpressure: `serial_ready` toggled pseudo-randomly →
  - `serial_out` stable while stalled.
  - Captured bytes equal `block_in` bytes 0..N-1.
  - No duplicated or lost chunks.
- `out_bytes=0` → DONE pulse the cycle after start; `block_ready` and `next_block` stay 0.
- Reset asserted mid-SHIFT at byte 10:
  - Next cycle: IDLE with all outputs 0.
  - A new `squeeze_start` with `out_bytes=2` completes normally.
- `SQUEEZE_MSB_FIRST_EN` build: byte 0x61 → chunks 01,10,00,01.
